fp_responder: RTL and testbench
===============================

Name: fp_responder

Overview:
- Responder end of the effect-side floating-point request interface.
- Audio effects act as initiators. Each holds `clk_en` high with operands and opcode, waits for a `done` pulse, reads `result` in that same cycle, then drops `clk_en`.
- This block accepts one request at a time and drives the shared vendor FP cores (add/sub, mul, int-to-float, float-to-int, compare).
- It tracks each core's fixed latency with a counter, captures and holds the result, and pulses `done`.

Parameters:
- `LAT_ADDSUB`, 7, add/sub core latency in clocks (1..15)
- `LAT_MUL`, 5, multiplier core latency (1..15)
- `LAT_ITOF`, 6, int-to-float core latency (1..15)
- `LAT_FTOI`, 6, float-to-int core latency (1..15)
- `LAT_CMP`, 1, compare core latency (1..15)

Ports:
- `clk` in 1: single clock
- `rst` in 1: asynchronous, active-high reset
- `clk_en` in 1: request valid, held high by the initiator until it has seen `done`
- `dataa` in 32: operand A (float, or sign-extended int for int-to-float)
- `datab` in 32: operand B
- `operation` in 3: opcode; 0 sub, 1 add, 3 mul, 4 float-to-int, 5 int-to-float, 6 compare
- `done` out 1: one-cycle completion pulse
- `result` out 32: result, held stable from `done` until the next capture
- `busy` out 1: high in BUSY, DONE and RELEASE
- `core_dataa` out 32: registered operand A to all cores
- `core_datab` out 32: registered operand B to all cores
- `core_add_sub` out 1: 1 selects add, 0 selects sub
- `core_clk_en` out 1: clock enable for the cores
- `addsub_result` in 32: add/sub core output
- `mul_result` in 32: multiplier core output
- `itof_result` in 32: int-to-float core output
- `ftoi_result` in 32: float-to-int core output
- `cmp_alb` in 1: compare core, A less than B
- `cmp_agb` in 1: compare core, A greater than B
- `cmp_aeb` in 1: compare core, A equal to B

Behaviour:
- Reset values: state IDLE; `done`=0, `result`=0, `busy`=0, `core_dataa`=0, `core_datab`=0, `core_add_sub`=1, `core_clk_en`=0; counter=0; latched opcode=1.
- Reset asserted mid-operation aborts immediately; there is no `done` pulse.
- State machine:
  - IDLE: on edge E with `clk_en`=1:
    - latch `dataa`/`datab` into `core_dataa`/`core_datab` and latch the opcode;
    - `core_add_sub`=1 for opcode 1, 0 otherwise;
    - counter := LAT for the opcode; `core_clk_en`:=1; go to BUSY.
    - Opcodes 2 and 7 are illegal: counter := 1, `core_clk_en` stays 0.
  - BUSY: counter decrements by 1 per edge.
    - If `clk_en`=0 is sampled: abort, `core_clk_en`:=0, go to IDLE, no `done`, `result` unchanged.
    - When counter=1 at an edge: `core_clk_en`:=0, `done`:=1, go to DONE, and `result` := selected source:
      - opcodes 0,1 → `addsub_result`; 3 → `mul_result`; 4 → `ftoi_result`; 5 → `itof_result`;
      - 6 → {29'b0, `cmp_alb`, `cmp_agb`, `cmp_aeb`}, so bit2=LESS, bit1=GREATER, bit0=EQUAL;
      - illegal opcode → 32'h0.
  - DONE: `done`:=0 at the next edge. Go to RELEASE if `clk_en`=1, IDLE if `clk_en`=0.
  - RELEASE: wait for `clk_en`=0, then go to IDLE. A request is never re-captured while the initiator is still dropping `clk_en` after `done`.
- Latency: `done` is high during the cycle following edge E+LAT. Minimum back-to-back spacing is LAT+3 clocks.
- `result` is registered. It is never driven straight from core outputs, so it holds across idle gaps.
- Operand or opcode changes while BUSY are ignored; only the values captured at E are used.
- Latency parameters outside 1..15 are illegal: simulation `$error` at elaboration.

Test Plan:
- Add: `clk_en`=1, op=1, A=0x3F800000, B=0x40000000, core model returns 0x40400000 after 7 clocks → `done` one cycle after edge E+7, `result`=0x40400000, `core_add_sub`=1, `core_clk_en` high for exactly 7 cycles.
- Compare: op=6, model `cmp_alb`=1 → `done` on the cycle after E+1, `result`=0x00000004; with `cmp_agb`=1 → 0x00000002.
- Initiator handshake: initiator drops `clk_en` the cycle after `done`; next request is issued immediately → no second `done` from the stale `clk_en`; second request captured only after IDLE; spacing LAT+3.
- Abort: `clk_en` dropped at cycle 3 of a mul → no `done`, `result` keeps its prior value, `core_clk_en` low, next mul completes normally after 5 clocks.
- Illegal op 7 → `done` after 1 clock, `result`=0, `core_clk_en` never asserted.
- Async reset asserted mid-BUSY (between edges) → all outputs return to reset values without waiting for a clock edge; no `done` after release.

Source files
------------

// File: rtl/fp_responder_if.sv
// fp_responder_if
// Request/response bundle between an audio effect (initiator) and the shared
// floating-point responder.
//
// Handshake: the initiator raises clk_en together with dataa, datab and
// operation, and holds clk_en high until it sees the one-cycle done pulse.
// It reads result in the done cycle and then drops clk_en. The responder
// captures a request only while idle and only when it samples clk_en high.
// If clk_en is dropped before done, the request is abandoned and done is
// never pulsed. busy tells the initiator that the responder is handling, or
// finishing, a request.
//
// Signals:
//   clk_en     request valid, held by the initiator until done is seen
//   dataa      operand A
//   datab      operand B
//   operation  opcode
//   done       one-cycle completion pulse
//   result     completed result, held until the next completion
//   busy       responder is occupied with a request
interface fp_responder_if;
    logic        clk_en;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic [2:0]  operation;
    logic        done;
    logic [31:0] result;
    logic        busy;

    modport master (
        output clk_en,
        output dataa,
        output datab,
        output operation,
        input  done,
        input  result,
        input  busy
    );

    modport slave (
        input  clk_en,
        input  dataa,
        input  datab,
        input  operation,
        output done,
        output result,
        output busy
    );
endinterface

// File: rtl/fp_responder.sv
// fp_responder
// Responder end of the effect-side floating-point request interface. It
// accepts one request at a time and feeds registered operands to the shared
// vendor FP cores (add/sub, mul, int-to-float, float-to-int, compare). A
// down-counter loaded with the fixed latency of the selected core marks when
// that core's output is valid. At that point the output is captured into a
// held result register, and done is pulsed.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   req             request/response bundle (slave side)
//   core_dataa/b    registered operands to all cores
//   core_add_sub    1 = add, 0 = subtract
//   core_clk_en     clock enable for the cores while a legal op is running
//   *_result, cmp_* core outputs
//   fsm_state       current state, for observation
//
// Opcodes: 0 sub, 1 add, 3 mul, 4 float-to-int, 5 int-to-float, 6 compare.
// Opcodes 2 and 7 are illegal. They complete after one clock with a zero
// result and never enable the cores.
module fp_responder #(
    parameter int LAT_ADDSUB = 7,
    parameter int LAT_MUL    = 5,
    parameter int LAT_ITOF   = 6,
    parameter int LAT_FTOI   = 6,
    parameter int LAT_CMP    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    fp_responder_if.slave        req,
    output logic [31:0]          core_dataa,
    output logic [31:0]          core_datab,
    output logic                 core_add_sub,
    output logic                 core_clk_en,
    input  logic [31:0]          addsub_result,
    input  logic [31:0]          mul_result,
    input  logic [31:0]          itof_result,
    input  logic [31:0]          ftoi_result,
    input  logic                 cmp_alb,
    input  logic                 cmp_agb,
    input  logic                 cmp_aeb,
    output logic [1:0]           fsm_state
);

    // Latencies outside 1..15 cannot be represented by the 4-bit counter.
    if (LAT_ADDSUB < 1 || LAT_ADDSUB > 15 || LAT_MUL < 1 || LAT_MUL > 15 ||
        LAT_ITOF < 1 || LAT_ITOF > 15 || LAT_FTOI < 1 || LAT_FTOI > 15 ||
        LAT_CMP < 1 || LAT_CMP > 15) begin : g_bad_latency
        $error("fp_responder: every core latency must lie in 1..15");
    end

    localparam logic [3:0] L_ADDSUB = 4'(LAT_ADDSUB);
    localparam logic [3:0] L_MUL    = 4'(LAT_MUL);
    localparam logic [3:0] L_ITOF   = 4'(LAT_ITOF);
    localparam logic [3:0] L_FTOI   = 4'(LAT_FTOI);
    localparam logic [3:0] L_CMP    = 4'(LAT_CMP);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BUSY    = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    logic [1:0]  state;
    logic [3:0]  count;
    logic [2:0]  op_q;
    logic        done_r;
    logic [31:0] result_r;

    logic [3:0]  start_lat;
    logic        start_legal;
    logic [31:0] capture_val;

    // Latency and legality of the opcode currently presented by the initiator.
    always_comb begin
        start_lat   = 4'd1;
        start_legal = 1'b1;
        case (req.operation)
            3'd0, 3'd1: start_lat = L_ADDSUB;
            3'd3:       start_lat = L_MUL;
            3'd4:       start_lat = L_FTOI;
            3'd5:       start_lat = L_ITOF;
            3'd6:       start_lat = L_CMP;
            default: begin
                start_lat   = 4'd1;
                start_legal = 1'b0;
            end
        endcase
    end

    // Core output selected by the latched opcode. Compare packs LESS,
    // GREATER and EQUAL into bits 2..0.
    always_comb begin
        capture_val = 32'h0;
        case (op_q)
            3'd0, 3'd1: capture_val = addsub_result;
            3'd3:       capture_val = mul_result;
            3'd4:       capture_val = ftoi_result;
            3'd5:       capture_val = itof_result;
            3'd6:       capture_val = {29'b0, cmp_alb, cmp_agb, cmp_aeb};
            default:    capture_val = 32'h0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            count        <= 4'd0;
            op_q         <= 3'd1;
            done_r       <= 1'b0;
            result_r     <= 32'h0;
            core_dataa   <= 32'h0;
            core_datab   <= 32'h0;
            core_add_sub <= 1'b1;
            core_clk_en  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req.clk_en) begin
                        core_dataa   <= req.dataa;
                        core_datab   <= req.datab;
                        op_q         <= req.operation;
                        core_add_sub <= (req.operation == 3'd1);
                        count        <= start_lat;
                        core_clk_en  <= start_legal;
                        state        <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // A dropped clk_en wins over completion on the same edge.
                    if (!req.clk_en) begin
                        core_clk_en <= 1'b0;
                        count       <= 4'd0;
                        state       <= S_IDLE;
                    end else if (count == 4'd1) begin
                        core_clk_en <= 1'b0;
                        count       <= 4'd0;
                        done_r      <= 1'b1;
                        result_r    <= capture_val;
                        state       <= S_DONE;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                S_DONE: begin
                    done_r <= 1'b0;
                    state  <= req.clk_en ? S_RELEASE : S_IDLE;
                end
                S_RELEASE: begin
                    // A clk_en still high after done belongs to the finished
                    // request. Wait until it drops before accepting another.
                    if (!req.clk_en) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign req.done   = done_r;
    assign req.result = result_r;
    assign req.busy   = (state != S_IDLE);
    assign fsm_state  = state;

endmodule

// File: tb/tb_fp_responder.sv
// tb_fp_responder
// Testbench for fp_responder. The core outputs are stimulus driven by the
// bench: fixed values in the directed section and new random values every
// cycle in the random section. A transaction-level reference model predicts
// every responder output on every clock.
module tb_fp_responder;
    localparam int LAT_ADDSUB = 7;
    localparam int LAT_MUL    = 5;
    localparam int LAT_ITOF   = 6;
    localparam int LAT_FTOI   = 6;
    localparam int LAT_CMP    = 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_responder_if bus ();

    logic [31:0] core_dataa, core_datab;
    logic        core_add_sub, core_clk_en;
    logic [31:0] addsub_result, mul_result, itof_result, ftoi_result;
    logic        cmp_alb, cmp_agb, cmp_aeb;
    logic [1:0]  fsm_state;

    fp_responder #(
        .LAT_ADDSUB(LAT_ADDSUB), .LAT_MUL(LAT_MUL), .LAT_ITOF(LAT_ITOF),
        .LAT_FTOI(LAT_FTOI), .LAT_CMP(LAT_CMP)
    ) dut (
        .clk(clk), .rst(rst), .req(bus.slave),
        .core_dataa(core_dataa), .core_datab(core_datab),
        .core_add_sub(core_add_sub), .core_clk_en(core_clk_en),
        .addsub_result(addsub_result), .mul_result(mul_result),
        .itof_result(itof_result), .ftoi_result(ftoi_result),
        .cmp_alb(cmp_alb), .cmp_agb(cmp_agb), .cmp_aeb(cmp_aeb),
        .fsm_state(fsm_state)
    );

    int errors = 0;
    int checks = 0;
    int tb_cyc = 0;

    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- core output stimulus ----------------
    bit          rand_core = 1'b0;
    logic [31:0] fix_addsub = 32'h0, fix_mul = 32'h0, fix_itof = 32'h0, fix_ftoi = 32'h0;
    logic [2:0]  fix_cmp = 3'b000;

    always @(negedge clk) begin
        if (rand_core) begin
            addsub_result <= $urandom;
            mul_result    <= $urandom;
            itof_result   <= $urandom;
            ftoi_result   <= $urandom;
            {cmp_alb, cmp_agb, cmp_aeb} <= 3'($urandom_range(0, 7));
        end else begin
            addsub_result <= fix_addsub;
            mul_result    <= fix_mul;
            itof_result   <= fix_itof;
            ftoi_result   <= fix_ftoi;
            {cmp_alb, cmp_agb, cmp_aeb} <= fix_cmp;
        end
    end

    // ---------------- reference model ----------------
    // A request occupies the responder from its capture until the initiator
    // lets go of clk_en. It completes LAT clocks after capture unless clk_en
    // is seen low first.
    function automatic int lat_of(input logic [2:0] op);
        case (op)
            3'd0, 3'd1: return LAT_ADDSUB;
            3'd3:       return LAT_MUL;
            3'd4:       return LAT_FTOI;
            3'd5:       return LAT_ITOF;
            3'd6:       return LAT_CMP;
            default:    return 1;
        endcase
    endfunction

    function automatic logic [31:0] pick(input logic [2:0] op);
        case (op)
            3'd0, 3'd1: return addsub_result;
            3'd3:       return mul_result;
            3'd4:       return ftoi_result;
            3'd5:       return itof_result;
            3'd6:       return {29'b0, cmp_alb, cmp_agb, cmp_aeb};
            default:    return 32'h0;
        endcase
    endfunction

    int          m_cyc, m_deadline;
    bit          m_active, m_hold;
    logic [2:0]  m_op;
    logic        e_done, e_busy, e_add_sub, e_core_en;
    logic [31:0] e_result, e_dataa, e_datab;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cyc <= 0; m_deadline <= 0; m_active <= 1'b0; m_hold <= 1'b0; m_op <= 3'd1;
            e_done <= 1'b0; e_busy <= 1'b0; e_add_sub <= 1'b1; e_core_en <= 1'b0;
            e_result <= 32'h0; e_dataa <= 32'h0; e_datab <= 32'h0;
        end else begin
            m_cyc  <= m_cyc + 1;
            e_done <= 1'b0;
            if (m_active) begin
                if (!bus.clk_en) begin
                    m_active <= 1'b0; e_core_en <= 1'b0; e_busy <= 1'b0;
                end else if (m_cyc == m_deadline) begin
                    m_active <= 1'b0; e_core_en <= 1'b0; e_done <= 1'b1;
                    e_result <= pick(m_op); m_hold <= 1'b1;
                end
            end else if (m_hold) begin
                if (!bus.clk_en) begin
                    m_hold <= 1'b0; e_busy <= 1'b0;
                end
            end else if (bus.clk_en) begin
                m_active   <= 1'b1;
                e_busy     <= 1'b1;
                m_op       <= bus.operation;
                e_dataa    <= bus.dataa;
                e_datab    <= bus.datab;
                e_add_sub  <= (bus.operation == 3'd1);
                e_core_en  <= (lat_of(bus.operation) > 0) && (bus.operation != 3'd2) && (bus.operation != 3'd7);
                m_deadline <= m_cyc + lat_of(bus.operation);
            end
        end
    end

    // ---------------- scoreboard: every-cycle compare ----------------
    always @(negedge clk) begin
        check32("done",         32'(bus.done),     32'(e_done));
        check32("busy",         32'(bus.busy),     32'(e_busy));
        check32("result",       bus.result,        e_result);
        check32("core_dataa",   core_dataa,        e_dataa);
        check32("core_datab",   core_datab,        e_datab);
        check32("core_add_sub", 32'(core_add_sub), 32'(e_add_sub));
        check32("core_clk_en",  32'(core_clk_en),  32'(e_core_en));
    end

    // ---------------- initiator driver ----------------
    // hold_extra: clocks the initiator keeps clk_en high after seeing done.
    // abort_at: drop clk_en after this many clocks without done (0 = never).
    task automatic do_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int abort_at, input int hold_extra,
                          output bit got_done, output int wait_n, output int en_n,
                          output logic [31:0] res, output int done_cyc);
        got_done = 1'b0; wait_n = 0; en_n = 0; res = 32'h0; done_cyc = 0;
        @(negedge clk);
        bus.clk_en = 1'b1; bus.dataa = a; bus.datab = b; bus.operation = op;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            wait_n = k;
            if (core_clk_en) en_n++;
            // Operand changes after capture must be ignored.
            bus.dataa = $urandom; bus.datab = $urandom; bus.operation = 3'($urandom_range(0, 7));
            if (bus.done) begin
                got_done = 1'b1; res = bus.result; done_cyc = tb_cyc;
                repeat (hold_extra) @(negedge clk);
                bus.clk_en = 1'b0;
                return;
            end
            if (k == abort_at) begin
                bus.clk_en = 1'b0;
                return;
            end
        end
        checks++; errors++;
        $display("FAIL req_timeout: got no done after 40 clocks, expected done for op %0d", op);
        bus.clk_en = 1'b0;
    endtask

    // ---------------- directed + random stimulus ----------------
    bit          gd;
    int          wn, en, dc, dc_prev, no_done;
    logic [31:0] rs;

    initial begin
        rst = 1'b1;
        bus.clk_en = 1'b0; bus.dataa = 32'h0; bus.datab = 32'h0; bus.operation = 3'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check32("rst_done",     32'(bus.done),     32'h0);
        check32("rst_result",   bus.result,        32'h0);
        check32("rst_busy",     32'(bus.busy),     32'h0);
        check32("rst_add_sub",  32'(core_add_sub), 32'h1);
        check32("rst_core_en",  32'(core_clk_en),  32'h0);
        check32("rst_dataa",    core_dataa,        32'h0);

        // Add 1.0 + 2.0 = 3.0, initiator drops clk_en one clock after done.
        fix_addsub = 32'h4040_0000;
        do_req(3'd1, 32'h3F80_0000, 32'h4000_0000, 0, 1, gd, wn, en, rs, dc_prev);
        check32("add_done",     32'(gd), 32'h1);
        check32("add_latency",  32'(wn), 32'd8);
        check32("add_core_en",  32'(en), 32'd7);
        check32("add_result",   rs,      32'h4040_0000);
        check32("add_sel",      32'(core_add_sub), 32'h1);

        // Immediate second add: captured only once the stale clk_en is gone.
        do_req(3'd1, 32'h4000_0000, 32'h4000_0000, 0, 1, gd, wn, en, rs, dc);
        check32("b2b_done",     32'(gd), 32'h1);
        check32("b2b_spacing",  32'(dc - dc_prev), 32'd10);

        // Compare: LESS then GREATER.
        fix_cmp = 3'b100;
        do_req(3'd6, 32'h3F80_0000, 32'h4000_0000, 0, 0, gd, wn, en, rs, dc);
        check32("cmp_lt_latency", 32'(wn), 32'd2);
        check32("cmp_lt_result",  rs,      32'h0000_0004);
        fix_cmp = 3'b010;
        do_req(3'd6, 32'h4000_0000, 32'h3F80_0000, 0, 0, gd, wn, en, rs, dc);
        check32("cmp_gt_result",  rs,      32'h0000_0002);

        // Subtract selects the subtract mode of the add/sub core.
        fix_addsub = 32'hBF80_0000;
        do_req(3'd0, 32'h3F80_0000, 32'h4000_0000, 0, 0, gd, wn, en, rs, dc);
        check32("sub_result",   rs,      32'hBF80_0000);
        check32("sub_sel",      32'(core_add_sub), 32'h0);

        // Abort a mul at cycle 3, then a normal mul.
        fix_mul = 32'h1234_5678;
        do_req(3'd3, 32'h4000_0000, 32'h4040_0000, 3, 0, gd, wn, en, rs, dc);
        @(negedge clk);
        check32("abort_no_done", 32'(gd), 32'h0);
        check32("abort_result",  bus.result, 32'hBF80_0000);
        check32("abort_core_en", 32'(core_clk_en), 32'h0);
        check32("abort_busy",    32'(bus.busy), 32'h0);
        do_req(3'd3, 32'h4000_0000, 32'h4040_0000, 0, 0, gd, wn, en, rs, dc);
        check32("mul_latency",  32'(wn), 32'd6);
        check32("mul_result",   rs,      32'h1234_5678);

        // Illegal opcode 7.
        do_req(3'd7, 32'hFFFF_FFFF, 32'h1, 0, 0, gd, wn, en, rs, dc);
        check32("ill_latency",  32'(wn), 32'd2);
        check32("ill_core_en",  32'(en), 32'd0);
        check32("ill_result",   rs,      32'h0);

        // Asynchronous reset in the middle of a mul.
        fix_mul = 32'hCAFE_F00D;
        @(negedge clk);
        bus.clk_en = 1'b1; bus.dataa = 32'h5555_AAAA; bus.datab = 32'h1; bus.operation = 3'd3;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check32("arst_busy",    32'(bus.busy),     32'h0);
        check32("arst_core_en", 32'(core_clk_en),  32'h0);
        check32("arst_dataa",   core_dataa,        32'h0);
        check32("arst_add_sub", 32'(core_add_sub), 32'h1);
        check32("arst_done",    32'(bus.done),     32'h0);
        @(negedge clk);
        bus.clk_en = 1'b0;
        rst = 1'b0;
        no_done = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.done) no_done++;
        end
        check32("arst_no_done", 32'(no_done), 32'h0);

        // Random traffic.
        rand_core = 1'b1;
        repeat (250) begin
            do_req(3'($urandom_range(0, 7)), $urandom, $urandom,
                   ($urandom_range(0, 4) == 0) ? $urandom_range(1, 8) : 0,
                   $urandom_range(0, 3), gd, wn, en, rs, dc);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end
endmodule
